// File: rtl/iterative_divider_if.sv
// ============================================================================
// iterative_divider_if : start/done handshake and operand/result bundle
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

interface iterative_divider_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;

  // master drives requests (ALU control); slave is the divider
  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder, div_by_zero
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder, div_by_zero
  );
endinterface

`default_nettype wire

// File: rtl/iterative_divider.sv
// ============================================================================
// iterative_divider : restoring unsigned divider, one quotient bit per clock
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module iterative_divider #(
  parameter int WIDTH = 8
) (
  input  logic              clk,
  input  logic              rst,
  iterative_divider_if.slave bus
);

  localparam int             CW   = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_next_state;
  logic [WIDTH-1:0] r_d;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH:0]   r_r;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_quotient;
  logic [WIDTH-1:0] r_remainder;
  logic             r_div_by_zero;

  logic             w_accept;
  logic             w_zero_div;
  logic             w_last;
  logic [WIDTH:0]   w_s;
  logic [WIDTH:0]   w_t;
  logic [WIDTH-1:0] w_q_step;
  logic [WIDTH:0]   w_r_step;

  assign w_accept   = ((r_state == IDLE) || (r_state == DONE)) && bus.start;
  assign w_zero_div = (bus.divisor == '0);
  assign w_last     = (r_cnt == LAST);

  // Trial subtract: a clear borrow bit (T[WIDTH]) means the divisor fits
  assign w_s      = {r_r[WIDTH-1:0], r_q[WIDTH-1]};
  assign w_t      = w_s + (~{1'b0, r_d}) + {{WIDTH{1'b0}}, 1'b1};
  assign w_q_step = {r_q[WIDTH-2:0], ~w_t[WIDTH]};
  assign w_r_step = w_t[WIDTH] ? w_s : w_t;

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE: begin
        if (bus.start) w_next_state = w_zero_div ? DONE : CALC;
      end
      CALC: begin
        if (w_last) w_next_state = DONE;
      end
      DONE: begin
        if (bus.start) w_next_state = w_zero_div ? DONE : CALC;
        else           w_next_state = IDLE;
      end
      default: w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_d           <= '0;
      r_q           <= '0;
      r_r           <= '0;
      r_cnt         <= '0;
      r_quotient    <= '0;
      r_remainder   <= '0;
      r_div_by_zero <= 1'b0;
    end else if (w_accept) begin
      r_d           <= bus.divisor;
      r_q           <= bus.dividend;
      r_r           <= '0;
      r_cnt         <= '0;
      r_div_by_zero <= w_zero_div;
      // Divide by zero skips iteration and publishes results immediately
      if (w_zero_div) begin
        r_quotient  <= '1;
        r_remainder <= bus.dividend;
      end
    end else if (r_state == CALC) begin
      r_q   <= w_q_step;
      r_r   <= w_r_step;
      r_cnt <= r_cnt + 1'b1;
      if (w_last) begin
        r_quotient  <= w_q_step;
        r_remainder <= w_r_step[WIDTH-1:0];
      end
    end
  end

  assign bus.busy        = (r_state == CALC);
  assign bus.done        = (r_state == DONE);
  assign bus.quotient    = r_quotient;
  assign bus.remainder   = r_remainder;
  assign bus.div_by_zero = r_div_by_zero;

endmodule

`default_nettype wire

// File: tb/tb_iterative_divider.sv
// ============================================================================
// tb_iterative_divider : directed and random checks of the iterative divider
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_iterative_divider;

  localparam int WIDTH = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  iterative_divider_if #(.WIDTH(WIDTH)) bus ();

  iterative_divider #(.WIDTH(WIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  logic [WIDTH-1:0] held_q;
  logic [WIDTH-1:0] held_r;
  logic             held_z;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: plain integer division with the divide-by-zero convention
  task automatic model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                       output logic [WIDTH-1:0] q, output logic [WIDTH-1:0] r,
                       output logic z);
    if (b == 0) begin
      q = '1; r = a; z = 1'b1;
    end else begin
      q = a / b; r = a % b; z = 1'b0;
    end
  endtask

  task automatic check_results(input string tag, input logic [WIDTH-1:0] a,
                               input logic [WIDTH-1:0] b);
    logic [WIDTH-1:0] eq, er;
    logic             ez;
    model(a, b, eq, er, ez);
    check({tag, "_done"}, bus.done, 1);
    check({tag, "_busy"}, bus.busy, 0);
    check({tag, "_q"}, bus.quotient, eq);
    check({tag, "_r"}, bus.remainder, er);
    check({tag, "_z"}, bus.div_by_zero, ez);
    held_q = eq; held_r = er; held_z = ez;
  endtask

  // One divide with a single-cycle start; checks busy, holding, latency, results
  task automatic run_div(input string tag, input logic [WIDTH-1:0] a,
                         input logic [WIDTH-1:0] b);
    int n;
    bus.start = 1'b1; bus.dividend = a; bus.divisor = b;
    tick();
    bus.start = 1'b0;
    bus.dividend = WIDTH'($urandom); bus.divisor = WIDTH'($urandom);
    n = 0;
    while (!bus.done && n < 20) begin
      check({tag, "_busy_calc"}, bus.busy, 1);
      check({tag, "_hold_q"}, bus.quotient, held_q);
      check({tag, "_hold_r"}, bus.remainder, held_r);
      tick();
      n++;
    end
    check({tag, "_latency"}, n, (b == 0) ? 0 : WIDTH);
    check_results(tag, a, b);
    tick();
    check({tag, "_pulse"}, bus.done, 0);
  endtask

  initial begin
    int n;
    int pulses;
    logic [WIDTH-1:0] ra, rb;

    rst = 1'b1;
    bus.start = 1'b0; bus.dividend = '0; bus.divisor = '0;
    held_q = '0; held_r = '0; held_z = 1'b0;
    tick(); tick();
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check("rst_q", bus.quotient, 0);
    check("rst_r", bus.remainder, 0);
    check("rst_z", bus.div_by_zero, 0);
    rst = 1'b0;

    // First start accepted on the first edge after reset release
    run_div("d200_7", 8'd200, 8'd7);
    run_div("d255_1", 8'd255, 8'd1);
    run_div("d5_9", 8'd5, 8'd9);
    run_div("d0_3", 8'd0, 8'd3);
    run_div("d255_255", 8'd255, 8'd255);
    run_div("d100_0", 8'd100, 8'd0);
    run_div("d9_3", 8'd9, 8'd3);

    // Start during CALC is ignored
    bus.start = 1'b1; bus.dividend = 8'd200; bus.divisor = 8'd7;
    tick();
    bus.start = 1'b0;
    n = 0;
    while (!bus.done && n < 20) begin
      if (n == 2) begin
        bus.start = 1'b1; bus.dividend = 8'd50; bus.divisor = 8'd5;
      end else begin
        bus.start = 1'b0;
      end
      tick();
      n++;
    end
    bus.start = 1'b0;
    check("ign_latency", n, WIDTH);
    check_results("ign", 8'd200, 8'd7);
    pulses = 0;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (bus.done || bus.busy) pulses++;
    end
    check("ign_single_done", pulses, 0);

    // Reset mid-operation abandons the divide
    bus.start = 1'b1; bus.dividend = 8'd200; bus.divisor = 8'd7;
    tick();
    bus.start = 1'b0;
    tick(); tick(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mrst_busy", bus.busy, 0);
    check("mrst_done", bus.done, 0);
    check("mrst_q", bus.quotient, 0);
    check("mrst_r", bus.remainder, 0);
    check("mrst_z", bus.div_by_zero, 0);
    pulses = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (bus.done || bus.busy) pulses++;
    end
    check("mrst_no_done", pulses, 0);
    held_q = '0; held_r = '0; held_z = 1'b0;
    run_div("d13_4", 8'd13, 8'd4);

    // Back-to-back with start held high
    bus.start = 1'b1; bus.dividend = 8'd200; bus.divisor = 8'd7;
    tick();
    n = 0;
    while (!bus.done && n < 20) begin tick(); n++; end
    check("b2b_lat1", n, WIDTH);
    check_results("b2b1", 8'd200, 8'd7);
    bus.dividend = 8'd81; bus.divisor = 8'd9;
    tick();
    n = 0;
    while (!bus.done && n < 20) begin tick(); n++; end
    check("b2b_gap", n + 1, WIDTH + 1);
    bus.start = 1'b0;
    check_results("b2b2", 8'd81, 8'd9);
    tick();
    check("b2b_end", bus.done, 0);

    // Random operands against the arithmetic model
    for (int i = 0; i < 40; i++) begin
      ra = WIDTH'($urandom);
      rb = ($urandom_range(0, 7) == 0) ? '0 : WIDTH'($urandom);
      run_div("rand", ra, rb);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
